lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, meaning the number of words in the attached memory; any access with word index >= MEM_WORDS is out of range.
REQ-002 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL have port req, input, 1, which starts an access when sampled high while ready=1.
REQ-005 SHALL have port we, input, 1: 1=store, 0=load.
REQ-006 SHALL have port funct3, input, 3, the RV32I size code: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
REQ-007 SHALL have port addr, input, WORD_LEN, the byte address.
REQ-008 SHALL have port wdata, input, WORD_LEN, the store data; only its low bytes are used for SB/SH.
REQ-009 SHALL have port ready, output, 1, high only in IDLE.
REQ-010 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1, qualified by done; high means the access was rejected.
REQ-012 SHALL have port rdata, output, WORD_LEN, the extended load result, qualified by done.
REQ-013 SHALL have port mem_addr, output, WORD_LEN, the word-aligned address sent to memory (low 2 bits = 0).
REQ-014 SHALL have port mem_wen, output, 1, the memory write enable.
REQ-015 SHALL have port mem_wdata, output, WORD_LEN, the memory write word.
REQ-016 SHALL have port mem_rdata, input, WORD_LEN, the memory read word; it is registered in memory and valid one edge after mem_addr is presented.

Function
REQ-017 SHALL latch we, funct3, addr and wdata on the accept edge T, defined as req=1 in IDLE.
REQ-018 SHALL implement FSM states IDLE, RD, EXT, WR, DONE.
REQ-019 SHALL follow these transitions: load IDLE->RD->EXT->DONE; SW IDLE->WR->DONE; SB/SH IDLE->RD->EXT->DONE; DONE->IDLE unconditionally.
REQ-020 SHALL drive mem_addr = {latched addr[31:2],2'b00} in RD, EXT and WR, and 0 in IDLE and DONE.
REQ-021 SHALL assert mem_wen only in WR (data = wdata) and in EXT for SB/SH (data = mem_rdata with the target byte/halfword replaced by wdata[7:0]/[15:0] at addr[1:0]/addr[1]); it is exactly one pulse per store.
REQ-022 SHALL, in EXT for loads, register into rdata the selected byte/halfword/word, sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-023 SHALL give latency from T to done: loads 3 cycles, SW 2 cycles, SB/SH 3 cycles, rejected accesses 1 cycle.
REQ-024 SHALL hold rdata until the next load's EXT; rdata is 0 for stores and for err.
REQ-025 SHALL reject unsupported funct3 (load 011/110/111, store >=011) and out-of-range addresses: IDLE->DONE with err=1, no mem_wen.
REQ-026 SHALL ignore req outside IDLE; req held high continuously starts a new access in the first IDLE cycle after DONE.

Reset
REQ-027 SHALL, while rst=1 at an edge, force state=IDLE, done=0, err=0, rdata=0; mem_wen and mem_addr are then 0.
REQ-028 SHALL, on reset mid-access (any state), abandon the access with no further mem_wen and no done pulse.
REQ-029 SHALL have ready=1 in the first cycle after rst is deasserted.

Configuration
REQ-030 SHALL, with LSU_MISALIGN_TRAP_EN defined, reject LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 per REQ-025.
REQ-031 SHALL, without LSU_MISALIGN_TRAP_EN, force offending low address bits to 0 and proceed normally; err is then set only for unsupported funct3 or out-of-range addresses.

Verification (memory word 0x100 preloaded 0x884422F1)
REQ-032 SHALL pass: LB addr 0x103 -> done 3 cycles after T, rdata=0xFFFFFF88, err=0; LBU 0x103 -> 0x00000088.
REQ-033 SHALL pass: LHU 0x102 -> rdata=0x00008844; LH 0x100 -> 0x000022F1.
REQ-034 SHALL pass: SB 0x101 wdata 0x123456AB -> one mem_wen pulse in EXT, mem_wdata=0x8844ABF1, then LW 0x100 returns 0x8844ABF1.
REQ-035 SHALL pass: SW 0x200 0xDEADBEEF -> done 2 cycles after T; LW 0x200 -> 0xDEADBEEF.
REQ-036 SHALL pass: LW 0x102 -> with macro, done 1 cycle after T, err=1, rdata=0, no memory access; without macro, rdata=0x884422F1, err=0. LW 0x4000 (MEM_WORDS=4096) -> err=1 in both builds.
REQ-037 SHALL pass: rst pulsed while an SB is in RD -> no mem_wen, no done, ready=1 after release, word 0x100 unchanged.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Request/response and memory-side bus of the load/store unit.
// The slave modport is the LSU; master is whoever drives requests and models memory.
interface lsu_ctrl_if #(
  parameter int WORD_LEN = 32
);
  logic                req;
  logic                we;
  logic [2:0]          funct3;
  logic [WORD_LEN-1:0] addr;
  logic [WORD_LEN-1:0] wdata;
  logic                ready;
  logic                done;
  logic                err;
  logic [WORD_LEN-1:0] rdata;
  logic [WORD_LEN-1:0] mem_addr;
  logic                mem_wen;
  logic [WORD_LEN-1:0] mem_wdata;
  logic [WORD_LEN-1:0] mem_rdata;

  modport master (
    output req, we, funct3, addr, wdata, mem_rdata,
    input  ready, done, err, rdata, mem_addr, mem_wen, mem_wdata
  );

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rdata,
    output ready, done, err, rdata, mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: byte/half/word loads and stores against a word memory with a registered read port.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of aligning them down.
module lsu_ctrl #(
  parameter int MEM_WORDS = 4096,
  parameter int WORD_LEN  = 32
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.slave  bus
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP = 1'b1;
`else
  localparam bit MISALIGN_TRAP = 1'b0;
`endif

  localparam logic [WORD_LEN-1:0] MEM_WORDS_W = WORD_LEN'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, RD, EXT, WR, DONE} state_t;

  state_t              state;
  state_t              state_next;

  logic                we_q;
  logic [2:0]          funct3_q;
  logic [WORD_LEN-1:0] addr_q;
  logic [WORD_LEN-1:0] wdata_q;

  logic                done_q;
  logic                err_q;
  logic [WORD_LEN-1:0] rdata_q;

  logic                accept;
  logic                bad_funct3;
  logic                misaligned;
  logic                out_of_range;
  logic                reject;
  logic [WORD_LEN-1:0] addr_fix;
  logic                sub_store;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [WORD_LEN-1:0] load_val;
  logic [WORD_LEN-1:0] merged;

  assign accept = (state == IDLE) && bus.req;

  // Request decode: legality, alignment, and the aligned-down address used when not trapping.
  // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it
  // holding its old value and no latch is inferred.
  always_comb begin
    bad_funct3 = 1'b0;
    misaligned = 1'b0;
    addr_fix   = bus.addr;
    if (bus.we) bad_funct3 = bus.funct3[2] || (bus.funct3[1:0] == 2'b11);
    else        bad_funct3 = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
    case (bus.funct3[1:0])
      2'b01: begin
        misaligned  = bus.addr[0];
        addr_fix[0] = 1'b0;
      end
      2'b10: begin
        misaligned    = |bus.addr[1:0];
        addr_fix[1:0] = 2'b00;
      end
      default: ;
    endcase
  end

  assign out_of_range = {2'b00, bus.addr[WORD_LEN-1:2]} >= MEM_WORDS_W;
  assign reject       = bad_funct3 || out_of_range || (MISALIGN_TRAP && misaligned);

  // NOTE: sequential state always uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (reject)                                    state_next = DONE;
          else if (bus.we && (bus.funct3[1:0] == 2'b10)) state_next = WR;
          else                                           state_next = RD;
        end
      end
      RD:      state_next = EXT;
      EXT:     state_next = DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the latched request fields carry no reset; they are only consumed after an accept
  // rewrites them, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= bus.we;
      funct3_q <= bus.funct3;
      addr_q   <= addr_fix;
      wdata_q  <= bus.wdata;
    end
  end

  assign sub_store = we_q && (funct3_q[1:0] != 2'b10);
  assign byte_sel  = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel  = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{(WORD_LEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{(WORD_LEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_val = {{(WORD_LEN-8){1'b0}}, byte_sel};
      3'b101:  load_val = {{(WORD_LEN-16){1'b0}}, half_sel};
      default: load_val = bus.mem_rdata;
    endcase
  end

  // Read-modify-write word for SB/SH: the old word arrives in EXT and is patched in place.
  always_comb begin
    merged = bus.mem_rdata;
    if (funct3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    bus.ready     = (state == IDLE);
    bus.mem_addr  = '0;
    bus.mem_wen   = 1'b0;
    bus.mem_wdata = '0;
    case (state)
      RD:  bus.mem_addr = {addr_q[WORD_LEN-1:2], 2'b00};
      EXT: begin
        bus.mem_addr = {addr_q[WORD_LEN-1:2], 2'b00};
        if (sub_store) begin
          bus.mem_wen   = 1'b1;
          bus.mem_wdata = merged;
        end
      end
      WR: begin
        bus.mem_addr  = {addr_q[WORD_LEN-1:2], 2'b00};
        bus.mem_wen   = 1'b1;
        bus.mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  // done/err are high exactly while in DONE; rdata clears for stores and rejects, else holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= (state_next == DONE);
      err_q  <= accept && reject;
      if (accept && (bus.we || reject)) rdata_q <= '0;
      else if ((state == EXT) && !we_q) rdata_q <= load_val;
    end
  end

  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule
